// File: rtl/motor_pwm_driver_if.sv
// Request/drive bundle between the steering logic, motor_pwm_driver and the dual H-bridge.
// The master side issues direction/enable/duty; the slave side (the driver) returns bridge drive.
interface motor_pwm_driver_if #(
    parameter int PWM_BITS = 8
);
    logic [3:0]          motorIn;
    logic [1:0]          motorEn;
    logic [PWM_BITS-1:0] duty;
    logic [3:0]          bridge_in;
    logic [1:0]          bridge_en;
    logic [1:0]          dead;

    modport master (
        output motorIn, motorEn, duty,
        input  bridge_in, bridge_en, dead
    );

    modport slave (
        input  motorIn, motorEn, duty,
        output bridge_in, bridge_en, dead
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// Dual-motor PWM output stage: synchronizes steering requests, ramps duty on start-up and
// inserts bridge-off dead time whenever a motor reverses or leaves brake towards a direction.
module motor_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_STEP   = 16
) (
    input logic               clk,
    input logic               rst_n,
    motor_pwm_driver_if.slave bus
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    localparam logic [1:0] REQ_COAST = 2'b00;
    localparam logic [1:0] REQ_B     = 2'b01;
    localparam logic [1:0] REQ_A     = 2'b10;
    localparam logic [1:0] REQ_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEAD,
        ST_BRAKE
    } state_e;

    logic [5:0]          sync1_q;
    logic [5:0]          sync2_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic                wrap;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {bus.motorEn, bus.motorIn};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_q + PWM_BITS'(1);
        end
    end

    assign wrap = &cnt_q;

    // Index 0 is the right motor (pair [1:0], enable bit 0), index 1 the left motor.
    for (genvar m = 0; m < 2; m++) begin : g_motor
        logic [1:0]          req;
        logic [PWM_BITS:0]   ramp_sum;
        logic [PWM_BITS-1:0] ramp_duty;

        state_e              state_q;
        logic [1:0]          dir_q;
        logic [PWM_BITS-1:0] cur_duty_q;
        logic [DW-1:0]       dead_cnt_q;
        logic [1:0]          pins_q;
        logic                en_q;
        logic                dead_q;

        assign req       = sync2_q[4+m] ? sync2_q[2*m +: 2] : REQ_COAST;
        assign ramp_sum  = {1'b0, cur_duty_q} + (PWM_BITS+1)'(RAMP_STEP);
        assign ramp_duty = (ramp_sum > {1'b0, bus.duty}) ? bus.duty : ramp_sum[PWM_BITS-1:0];

        // Outputs are registered alongside the state, so each branch drives the values of the
        // state being entered; the defaults below describe the bridge-off condition.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= ST_IDLE;
                dir_q      <= REQ_COAST;
                cur_duty_q <= '0;
                dead_cnt_q <= '0;
                pins_q     <= REQ_COAST;
                en_q       <= 1'b0;
                dead_q     <= 1'b0;
            end else begin
                pins_q     <= REQ_COAST;
                en_q       <= 1'b0;
                dead_q     <= 1'b0;
                cur_duty_q <= '0;

                case (state_q)
                    ST_IDLE: begin
                        if (req == REQ_A || req == REQ_B) begin
                            state_q <= ST_RUN;
                            dir_q   <= req;
                            pins_q  <= req;
                        end else if (req == REQ_BRAKE) begin
                            state_q <= ST_BRAKE;
                            pins_q  <= REQ_BRAKE;
                            en_q    <= 1'b1;
                        end
                    end

                    ST_RUN: begin
                        if (req == REQ_COAST) begin
                            state_q <= ST_IDLE;
                        end else if (req == REQ_BRAKE) begin
                            state_q <= ST_BRAKE;
                            pins_q  <= REQ_BRAKE;
                            en_q    <= 1'b1;
                        end else if (req != dir_q) begin
                            state_q    <= ST_DEAD;
                            dir_q      <= req;
                            dead_cnt_q <= DEAD_LOAD;
                            dead_q     <= 1'b1;
                        end else begin
                            pins_q     <= dir_q;
                            en_q       <= (cnt_q < cur_duty_q);
                            cur_duty_q <= wrap ? ramp_duty : cur_duty_q;
                        end
                    end

                    ST_DEAD: begin
                        // The latest request is the exit target; the count is never restarted.
                        dir_q <= req;
                        if (dead_cnt_q != '0) begin
                            dead_cnt_q <= dead_cnt_q - DW'(1);
                            dead_q     <= 1'b1;
                        end else if (req == REQ_COAST) begin
                            state_q <= ST_IDLE;
                        end else if (req == REQ_BRAKE) begin
                            state_q <= ST_BRAKE;
                            pins_q  <= REQ_BRAKE;
                            en_q    <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            pins_q  <= req;
                        end
                    end

                    ST_BRAKE: begin
                        if (req == REQ_A || req == REQ_B) begin
                            state_q    <= ST_DEAD;
                            dir_q      <= req;
                            dead_cnt_q <= DEAD_LOAD;
                            dead_q     <= 1'b1;
                        end else if (req == REQ_COAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            pins_q <= REQ_BRAKE;
                            en_q   <= 1'b1;
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.bridge_in = {g_motor[1].pins_q, g_motor[0].pins_q};
    assign bus.bridge_en = {g_motor[1].en_q,   g_motor[0].en_q};
    assign bus.dead      = {g_motor[1].dead_q, g_motor[0].dead_q};

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed scenarios plus randomized request streams,
// every cycle compared against a behavioural model of the motor rules.
module tb_motor_pwm_driver;

    localparam int PWM_BITS    = 8;
    localparam int DEAD_CYCLES = 16;
    localparam int RAMP_STEP   = 16;
    localparam int PERIOD      = 1 << PWM_BITS;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DEAD  = 2;
    localparam int M_BRAKE = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    motor_pwm_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

    motor_pwm_driver #(
        .PWM_BITS   (PWM_BITS),
        .DEAD_CYCLES(DEAD_CYCLES),
        .RAMP_STEP  (RAMP_STEP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural model: per-motor state, duty, direction and remaining dead clocks.
    int m_st[2];
    int m_dr[2];
    int m_dc[2];
    int m_cd[2];
    int m_pins[2];
    int m_en[2];
    int m_dead[2];
    int ticks;
    int hist[$];

    // Observed tallies for aggregate checks over a window.
    int en_hi[2];
    int dead_hi[2];
    int pins_nz_l;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m] = M_IDLE; m_dr[m] = 0; m_dc[m] = 0; m_cd[m] = 0;
            m_pins[m] = 0; m_en[m] = 0; m_dead[m] = 0;
        end
        ticks = 0;
        hist  = '{0, 0};
    endtask

    // Advance the model across one rising edge using the inputs present before that edge.
    task automatic model_edge();
        int word, c, d;
        word = hist.pop_front();
        hist.push_back(int'({bus.motorEn, bus.motorIn}));
        c = ticks % PERIOD;
        d = int'(bus.duty);
        ticks++;
        for (int m = 0; m < 2; m++) begin
            int r, prev, nxt, sum;
            r    = ((word >> (4 + m)) & 1) != 0 ? ((word >> (2 * m)) & 3) : 0;
            prev = m_st[m];
            nxt  = prev;
            case (prev)
                M_IDLE: begin
                    if (r == 1 || r == 2) begin nxt = M_RUN; m_dr[m] = r; end
                    else if (r == 3) nxt = M_BRAKE;
                end
                M_RUN: begin
                    if (r == 0) nxt = M_IDLE;
                    else if (r == 3) nxt = M_BRAKE;
                    else if (r != m_dr[m]) begin
                        nxt = M_DEAD; m_dr[m] = r; m_dc[m] = DEAD_CYCLES - 1;
                    end
                end
                M_DEAD: begin
                    if (m_dc[m] > 0) m_dc[m]--;
                    else if (r == 0) nxt = M_IDLE;
                    else if (r == 3) nxt = M_BRAKE;
                    else begin nxt = M_RUN; m_dr[m] = r; end
                end
                default: begin
                    if (r == 1 || r == 2) begin
                        nxt = M_DEAD; m_dr[m] = r; m_dc[m] = DEAD_CYCLES - 1;
                    end else if (r == 0) nxt = M_IDLE;
                end
            endcase
            m_en[m]   = (nxt == M_BRAKE || (nxt == M_RUN && c < m_cd[m])) ? 1 : 0;
            m_pins[m] = (nxt == M_RUN) ? m_dr[m] : (nxt == M_BRAKE) ? 3 : 0;
            m_dead[m] = (nxt == M_DEAD) ? 1 : 0;
            if (nxt != M_RUN) m_cd[m] = 0;
            else if (prev == M_RUN && c == PERIOD - 1) begin
                sum     = m_cd[m] + RAMP_STEP;
                m_cd[m] = (sum > d) ? d : sum;
            end
            m_st[m] = nxt;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("bridge_in", 32'(bus.bridge_in), m_pins[1] * 4 + m_pins[0]);
        check("bridge_en", 32'(bus.bridge_en), m_en[1] * 2 + m_en[0]);
        check("dead",      32'(bus.dead),      m_dead[1] * 2 + m_dead[0]);
        for (int m = 0; m < 2; m++) begin
            en_hi[m]   += int'(bus.bridge_en[m]);
            dead_hi[m] += int'(bus.dead[m]);
        end
        pins_nz_l += (bus.bridge_in[3:2] != 2'b00) ? 1 : 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic align();
        while (ticks % PERIOD != 0) cycle();
    endtask

    task automatic clear_tally();
        en_hi     = '{0, 0};
        dead_hi   = '{0, 0};
        pins_nz_l = 0;
    endtask

    task automatic drive(input logic [3:0] in_v, input logic [1:0] en_v, input int duty_v);
        bus.motorIn = in_v;
        bus.motorEn = en_v;
        bus.duty    = PWM_BITS'(duty_v);
    endtask

    initial begin
        drive(4'b0000, 2'b00, 0);
        model_reset();
        clear_tally();
        #22 rst_n = 1'b1;

        check("rst_bridge_in", 32'(bus.bridge_in), 0);
        check("rst_bridge_en", 32'(bus.bridge_en), 0);
        check("rst_dead",      32'(bus.dead),      0);

        // Forward on both motors, ramp to 128.
        drive(4'b0110, 2'b11, 128);
        run(2);
        check("latency_2clk", 32'(bus.bridge_in), 0);
        run(1);
        check("latency_3clk", 32'(bus.bridge_in), 4'b0110);
        align();
        for (int k = 1; k <= 9; k++) begin
            int exp_d;
            exp_d = (k * RAMP_STEP > 128) ? 128 : k * RAMP_STEP;
            clear_tally();
            run(PERIOD);
            check("ramp_left",  en_hi[1], exp_d);
            check("ramp_right", en_hi[0], exp_d);
        end

        // Reverse the left motor only.
        drive(4'b1010, 2'b11, 128);
        clear_tally();
        run(300);
        check("rev_dead_left",   dead_hi[1], DEAD_CYCLES);
        check("rev_dead_right",  dead_hi[0], 0);
        check("rev_left_in_off", 300 - pins_nz_l, DEAD_CYCLES);

        // Left disabled, right reversed.
        drive(4'b0101, 2'b01, 128);
        run(3);
        clear_tally();
        run(600);
        check("dis_left_en",  en_hi[1], 0);
        check("dis_left_pin", pins_nz_l, 0);

        // Brake both, then release into run.
        drive(4'b1111, 2'b11, 128);
        run(3);
        check("brake_in", 32'(bus.bridge_in), 4'hf);
        check("brake_en", 32'(bus.bridge_en), 2'b11);
        clear_tally();
        run(20);
        check("brake_en_hold", en_hi[1] + en_hi[0], 40);
        drive(4'b0110, 2'b11, 128);
        clear_tally();
        run(300);
        check("brake_dead_left",  dead_hi[1], DEAD_CYCLES);
        check("brake_dead_right", dead_hi[0], DEAD_CYCLES);

        // Asynchronous reset at full ramp.
        run(9 * PERIOD);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_in",   32'(bus.bridge_in), 0);
        check("async_rst_en",   32'(bus.bridge_en), 0);
        check("async_rst_dead", 32'(bus.dead),      0);
        model_reset();
        #9 rst_n = 1'b1;
        clear_tally();
        run(200);
        check("post_rst_no_pulse", en_hi[1] + en_hi[0], 0);

        // Zero duty, then full duty.
        drive(4'b0110, 2'b11, 0);
        run(PERIOD);
        align();
        clear_tally();
        run(PERIOD);
        check("duty0_en", en_hi[1] + en_hi[0], 0);
        drive(4'b0110, 2'b11, 255);
        run(17 * PERIOD);
        align();
        clear_tally();
        run(PERIOD);
        check("duty255_low_left",  PERIOD - en_hi[1], 1);
        check("duty255_low_right", PERIOD - en_hi[0], 1);

        // Randomized request streams, including short holds that re-target during dead time.
        for (int s = 0; s < 60; s++) begin
            int hold;
            drive(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
                  int'($urandom_range(0, 255)));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                               : int'($urandom_range(20, 600));
            run(hold);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Output stage between the line-follow steering logic and the dual H-bridge. Consumes the steering block's 4-bit direction word (`motorIn`: [3:2] left pair, [1:0] right pair) and 2-bit enable (`motorEn`). Produces PWM-modulated bridge enables with per-motor soft-start ramp and dead time on direction reversal. This protects the bridge and gearbox from the hard reversals the steering logic commands.

## Interface
- `PWM_BITS`, 8: width of PWM counter and duty values.
- `DEAD_CYCLES`, 16: clocks with the bridge off between opposite directions on one motor (≥1).
- `RAMP_STEP`, 16: duty increment applied at each PWM period wrap while ramping.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `motorIn`  in  4  direction request; per pair 10 = dir A, 01 = dir B, 00 = coast, 11 = brake.
- `motorEn`  in  2  enable request; [1] left, [0] right.
- `duty`  in  PWM_BITS  target duty, shared by both motors; sampled continuously.
- `bridge_in`  out  4  registered direction pins to the H-bridge, same bit layout as `motorIn`.
- `bridge_en`  out  2  registered PWM enables; [1] left, [0] right.
- `dead`  out  2  high while the corresponding motor is in DEAD.

## Operation
- `motorIn`/`motorEn` pass through a 2-flop synchronizer; all decisions use the synchronized values.
- Free-running PWM counter `cnt` counts 0 .. 2^PWM_BITS−1 and wraps. `wrap` is high in the cycle `cnt` equals all-ones.
- Each motor has an independent FSM with its own `cur_duty` (PWM_BITS), `dir` (2 bits) and dead counter.
- Per motor, the request is `req`, the pair from `motorIn`. It is forced to 00 when that motor's `motorEn` bit is 0.
- FSM states and transitions:
  - IDLE: `bridge_in` pair = 00, `bridge_en` = 0, `cur_duty` = 0.
    - `req` 10/01 → RUN with `dir`=`req`.
    - `req` 11 → BRAKE.
  - RUN: `bridge_in` pair = `dir`; `bridge_en` = (`cnt` < `cur_duty`).
    - At each `wrap`, `cur_duty` = min(`cur_duty`+RAMP_STEP, `duty`); the add is done at PWM_BITS+1 width and saturates.
    - If `duty` drops below `cur_duty`, `cur_duty` = `duty` at the next `wrap`; there is no downward ramp.
    - `req` 00 → IDLE.
    - `req` 11 → BRAKE.
    - `req` equal to the opposite direction → DEAD, loading the counter with DEAD_CYCLES−1 and latching the new `dir`.
    - `req` equal to `dir` → stay.
  - DEAD: `bridge_in` pair = 00, `bridge_en` = 0, `cur_duty` = 0; counter decrements each clock.
    - At 0 → RUN with the latched `dir`; the ramp restarts from 0.
    - A `req` change during DEAD updates the latched target: 10/01 re-latch `dir` without restarting the count; 00 → IDLE at expiry; 11 → BRAKE at expiry.
  - BRAKE: `bridge_in` pair = 11, `bridge_en` = 1 constantly, `cur_duty` = 0.
    - `req` 10/01 → DEAD, then RUN.
    - `req` 00 → IDLE.
- `dead[i]` = 1 exactly while motor i is in DEAD.
- `duty` = 0 in RUN gives `bridge_en` constantly 0. Full on is never reached: maximum high time is 2^PWM_BITS−1 of 2^PWM_BITS clocks.

## Timing
- Reset values: all outputs 0, both FSMs in IDLE, `cnt` = 0, `cur_duty` = 0, synchronizers cleared.
- Reset asserted mid-operation forces all outputs to 0 immediately (asynchronously). Bridge direction is never held across reset.
- Latency: a change on `motorIn`/`motorEn` reaches `bridge_in`/`dead` in exactly 3 clocks (2 synchronizer + 1 output register).
- Dead time: `bridge_en` is low for at least DEAD_CYCLES+1 clocks between the last high pulse in one direction and the first in the other. `bridge_in` reads 00 for exactly DEAD_CYCLES clocks.
- Ramp: starting from 0, RUN reaches target `duty` D after ceil(D/RAMP_STEP) wraps.
- `bridge_en` and `bridge_in` change only on `clk` rising edges and are glitch-free.
- Both motors reversing in the same cycle: each runs its own DEAD independently and both exit on the same clock.

## Test plan
- Reset, then hold `motorIn`=0110, `motorEn`=11, `duty`=128 → 3 clocks later `bridge_in`=0110. `cur_duty` steps 0,16,…,128 over 8 wraps. After that, `bridge_en` is high 128 of every 256 clocks on both bits.
- From steady RUN at 0110, switch to `motorIn`=1010 → left pair only: `dead`=10 for 16 clocks with `bridge_in`[3:2]=00 and `bridge_en`[1]=0, then `bridge_in`=1010 and the left ramp restarts from 0. The right motor is unaffected.
- `motorEn`=01 with `motorIn`=0101 → left outputs stay 00/0; right runs direction 01 with ramp.
- `motorIn`=1111, `motorEn`=11 → `bridge_in`=1111, `bridge_en`=11 constant after 3 clocks. Changing to 0110 → 16 dead clocks, then ramp.
- During RUN at full ramp, assert `rst_n`=0 for 1 clock, asynchronous to `clk` → outputs go 0 without waiting for an edge. After release, the ramp restarts from 0.
- `duty`=0 in RUN → `bridge_en`=0 for the full period. Raising `duty` to 255 → `cur_duty` saturates at 255 after 16 wraps, and `bridge_en` is low exactly 1 clock per period.
